spi_packet_decoder: RTL and testbench

- Sits between the SPI slave word receiver and the command/MIL dispatch logic of the MIL-SPI bridge.
- Parses framed SPI packets: address word, header {size, cmd}, `size` data words, checksum word, trailer word.
- Drops packets that are foreign-addressed, corrupt, aborted or oversized.
- Buffers accepted packets in a packet FIFO and releases each one downstream only after its checksum is verified.

---
 rtl/spi_packet_decoder_if.sv | 27 ++
 rtl/spi_packet_decoder.sv | 162 ++++++++++++++++
 tb/tb_spi_packet_decoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_packet_decoder_if.sv
// Bus between the SPI word receiver, the packet decoder and the downstream dispatcher.
// in_valid/frame_end are strobes with no backpressure; the out_* beat transfers on out_valid && out_ready,
// and out_data/out_first/out_last stay stable while out_valid is high and out_ready is low.
interface spi_packet_decoder_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        frame_end;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_first;
  logic        out_last;
  logic        pkt_ok;
  logic        err_csum;
  logic        err_ovf;
  logic        busy;

  modport slave (
    input  in_valid, in_data, frame_end, out_ready,
    output out_valid, out_data, out_first, out_last, pkt_ok, err_csum, err_ovf, busy
  );

  modport master (
    output in_valid, in_data, frame_end, out_ready,
    input  out_valid, out_data, out_first, out_last, pkt_ok, err_csum, err_ovf, busy
  );
endinterface

// File: rtl/spi_packet_decoder.sv
// Framed SPI packet parser: address, header {size,cmd}, data, checksum, trailer.
// Accepted packets are staged in a FIFO and only become readable once their checksum commits.
module spi_packet_decoder #(
  parameter logic [7:0] BLOCK_ADDR = 8'hAB,
  parameter int         FIFO_DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_packet_decoder_if.slave  bus,
  output logic [2:0]           o_dbg_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_ADDR, S_HDR, S_DATA, S_CSUM, S_TAIL} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_sum, w_sum_nxt;
  logic          r_match, w_match_nxt;
  logic          r_keep, w_keep_nxt;
  logic [7:0]    r_cnt, w_cnt_nxt;
  logic [PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [PW-1:0] r_commit_ptr, w_commit_nxt;
  logic [PW-1:0] r_rd_ptr, w_rd_nxt;
  logic          w_wr_en;
  logic [17:0]   w_wr_word;
  logic          w_pkt_ok, w_err_csum, w_err_ovf;
  logic          r_pkt_ok, r_err_csum, r_err_ovf;
  logic          r_out_valid;
  logic [17:0]   r_out_word;
  logic [17:0]   r_mem [FIFO_DEPTH];

  logic [7:0]    w_size;
  logic [PW-1:0] w_used;
  logic [15:0]   w_free;
  logic [15:0]   w_need;
  logic          w_hdr_keep;
  logic          w_rd_accept;

  assign w_size     = bus.in_data[15:8];
  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_free     = 16'(FIFO_DEPTH) - 16'(w_used);
  assign w_need     = 16'(w_size) + 16'd1;
  assign w_hdr_keep = r_match && (w_free >= w_need);

  always_comb begin
    w_state_nxt  = r_state;
    w_sum_nxt    = r_sum;
    w_match_nxt  = r_match;
    w_keep_nxt   = r_keep;
    w_cnt_nxt    = r_cnt;
    w_wr_ptr_nxt = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_wr_en      = 1'b0;
    w_wr_word    = '0;
    w_pkt_ok     = 1'b0;
    w_err_csum   = 1'b0;
    w_err_ovf    = 1'b0;
    if (bus.in_valid) begin
      case (r_state)
        S_ADDR: begin
          w_sum_nxt   = bus.in_data;
          w_match_nxt = (bus.in_data[15:8] == BLOCK_ADDR);
          w_keep_nxt  = 1'b0;
          w_state_nxt = S_HDR;
        end
        S_HDR: begin
          w_cnt_nxt  = w_size;
          w_sum_nxt  = r_sum + bus.in_data;
          w_keep_nxt = w_hdr_keep;
          w_err_ovf  = r_match && !w_hdr_keep;
          if (w_hdr_keep) begin
            w_wr_en      = 1'b1;
            w_wr_word    = {1'b1, (w_size == 8'd0), bus.in_data};
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
          end
          w_state_nxt = (w_size != 8'd0) ? S_DATA : S_CSUM;
        end
        S_DATA: begin
          w_sum_nxt = r_sum + bus.in_data;
          if (r_keep) begin
            w_wr_en      = 1'b1;
            w_wr_word    = {1'b0, (r_cnt == 8'd1), bus.in_data};
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
          end
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_state_nxt = S_CSUM;
        end
        S_CSUM: begin
          if (r_keep) begin
            if (bus.in_data == r_sum) begin
              w_commit_nxt = r_wr_ptr;
              w_pkt_ok     = 1'b1;
            end else begin
              w_wr_ptr_nxt = r_commit_ptr;
              w_err_csum   = 1'b1;
            end
          end
          w_state_nxt = S_TAIL;
        end
        S_TAIL:  w_state_nxt = S_ADDR;
        default: w_state_nxt = S_ADDR;
      endcase
    end
    // The word in this cycle is processed first; anything still uncommitted is then discarded.
    if (bus.frame_end) begin
      w_state_nxt  = S_ADDR;
      w_wr_ptr_nxt = w_commit_nxt;
    end
  end

  assign w_rd_accept = r_out_valid && bus.out_ready;
  assign w_rd_nxt    = w_rd_accept ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_ADDR;
      r_sum        <= '0;
      r_match      <= 1'b0;
      r_keep       <= 1'b0;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_pkt_ok     <= 1'b0;
      r_err_csum   <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_word   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sum        <= w_sum_nxt;
      r_match      <= w_match_nxt;
      r_keep       <= w_keep_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_rd_ptr     <= w_rd_nxt;
      r_pkt_ok     <= w_pkt_ok;
      r_err_csum   <= w_err_csum;
      r_err_ovf    <= w_err_ovf;
      // Uses the current commit_ptr, so the first beat lands one cycle after the pkt_ok pulse.
      r_out_valid  <= (w_rd_nxt != r_commit_ptr);
      r_out_word   <= r_mem[w_rd_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_word;
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_first = r_out_word[17];
  assign bus.out_last  = r_out_word[16];
  assign bus.out_data  = r_out_word[15:0];
  assign bus.pkt_ok    = r_pkt_ok;
  assign bus.err_csum  = r_err_csum;
  assign bus.err_ovf   = r_err_ovf;
  assign bus.busy      = (r_state != S_ADDR);
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_spi_packet_decoder.sv
// Directed bench for spi_packet_decoder: packets go in from the main process, expected beats
// are queued, and a negedge monitor pops and compares every accepted beat and counts pulses.
module tb_spi_packet_decoder;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_packet_decoder_if bus();
  logic [2:0] dbg_state;

  spi_packet_decoder #(.BLOCK_ADDR(8'hAB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cnt_ok = 0, cnt_csum = 0, cnt_ovf = 0;
  int ready_mode = 1;  // 0: always ready, 1: never ready, 2: random
  logic [17:0] exp_q[$];
  logic [15:0] tx_q[$];
  logic        stall_prev = 1'b0;
  logic [17:0] beat_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_beat", {14'd0, bus.out_first, bus.out_last, bus.out_data}, {14'd0, beat_prev});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL beat_unexpected: got %0h with nothing expected",
                   {bus.out_first, bus.out_last, bus.out_data});
        end else begin
          check("beat", {14'd0, bus.out_first, bus.out_last, bus.out_data}, {14'd0, exp_q.pop_front()});
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      beat_prev  = {bus.out_first, bus.out_last, bus.out_data};
      if (bus.pkt_ok)   cnt_ok++;
      if (bus.err_csum) cnt_csum++;
      if (bus.err_ovf)  cnt_ovf++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [15:0] w, input logic fe);
    bus.in_valid  = 1'b1;
    bus.in_data   = w;
    bus.frame_end = fe;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.frame_end = 1'b0;
  endtask

  task automatic send_tx();
    while (tx_q.size() != 0) send_word(tx_q.pop_front(), 1'b0);
  endtask

  task automatic expect_beat(input logic [15:0] d, input logic f, input logic l);
    exp_q.push_back({f, l, d});
  endtask

  // Builds address, header, data base+i, checksum, trailer; optionally queues the expected beats.
  task automatic build_pkt(input logic [7:0] addr, input logic [7:0] size, input logic [7:0] cmd,
                           input logic [15:0] base, input bit push_exp);
    logic [15:0] s;
    logic [15:0] d;
    s = {addr, 8'h00} + {size, cmd};
    tx_q.push_back({addr, 8'h00});
    tx_q.push_back({size, cmd});
    if (push_exp) expect_beat({size, cmd}, 1'b1, (size == 8'd0));
    for (int i = 0; i < int'(size); i++) begin
      d = base + 16'(i);
      s = s + d;
      tx_q.push_back(d);
      if (push_exp) expect_beat(d, 1'b0, (i == int'(size) - 1));
    end
    tx_q.push_back(s);
    tx_q.push_back(16'h0000);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    repeat (3) begin @(posedge clk); #1; end
    while ((exp_q.size() != 0 || bus.out_valid) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= max) begin
      n_errors++;
      $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", exp_q.size(), max);
      exp_q.delete();
    end
  endtask

  task automatic check_counts(input string name, input int ok, input int cs, input int ov);
    check({name, "_pkt_ok"}, cnt_ok, ok);
    check({name, "_err_csum"}, cnt_csum, cs);
    check({name, "_err_ovf"}, cnt_ovf, ov);
    cnt_ok = 0; cnt_csum = 0; cnt_ovf = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.frame_end = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {25'd0, bus.out_valid, bus.out_first, bus.out_last, bus.pkt_ok,
                          bus.err_csum, bus.err_ovf, bus.busy}, 32'd0);
    check("reset_data", {16'd0, bus.out_data}, 32'd0);
    check("reset_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    ready_mode = 0;

    // Good packet from hand-computed vectors
    tx_q = '{16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1,
             16'h5BCF, 16'h0000};
    expect_beat(16'h06A2, 1'b1, 1'b0);
    expect_beat(16'hFFA1, 1'b0, 1'b0);
    expect_beat(16'h0001, 1'b0, 1'b0);
    expect_beat(16'h0002, 1'b0, 1'b0);
    expect_beat(16'hAB45, 1'b0, 1'b0);
    expect_beat(16'hFFA3, 1'b0, 1'b0);
    expect_beat(16'hFFA1, 1'b0, 1'b1);
    send_word(tx_q.pop_front(), 1'b0);
    check("busy_in_packet", {31'd0, bus.busy}, 32'd1);
    send_tx();
    wait_idle(100);
    check_counts("good", 1, 0, 0);

    // Bad checksum, then a size-0 packet
    tx_q = '{16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45, 16'hFFA3, 16'hFFA1,
             16'h5BCE, 16'h0000, 16'hAB00, 16'h00B0, 16'hABB0, 16'h0000};
    expect_beat(16'h00B0, 1'b1, 1'b1);
    send_tx();
    wait_idle(100);
    check_counts("badcsum", 1, 1, 0);

    // Foreign addresses (including one with data that looks like our header) then ours
    tx_q = '{16'h0100, 16'h00A0, 16'h01A0, 16'h0000};
    build_pkt(8'h01, 8'd2, 8'h00, 16'hAB00, 1'b0);
    tx_q.push_back(16'hAB00); tx_q.push_back(16'h00A0);
    tx_q.push_back(16'hABA0); tx_q.push_back(16'h0000);
    expect_beat(16'h00A0, 1'b1, 1'b1);
    send_tx();
    wait_idle(100);
    check_counts("foreign", 1, 0, 0);

    // Abort mid-data; a full-FIFO packet afterwards proves the space came back
    send_word(16'hAB00, 1'b0);
    send_word(16'h06A2, 1'b0);
    send_word(16'hFFA1, 1'b0);
    bus.frame_end = 1'b1;
    @(posedge clk); #1;
    bus.frame_end = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    build_pkt(8'hAB, 8'd7, 8'hC1, 16'h0001, 1'b1);
    send_tx();
    wait_idle(100);
    check_counts("abort", 1, 0, 0);

    // Overflow under backpressure, then drain with random stalls
    ready_mode = 1;
    build_pkt(8'hAB, 8'd4, 8'h11, 16'h1000, 1'b1);
    build_pkt(8'hAB, 8'd4, 8'h22, 16'h2000, 1'b0);
    send_tx();
    repeat (3) begin @(posedge clk); #1; end
    check("ovf_held_valid", {31'd0, bus.out_valid}, 32'd1);
    check("ovf_held_hdr", {15'd0, bus.out_first, bus.out_data}, {15'd0, 1'b1, 16'h0411});
    check_counts("ovf", 1, 0, 1);
    ready_mode = 2;
    wait_idle(300);
    ready_mode = 0;

    // Checksum word arriving together with frame_end still commits
    build_pkt(8'hAB, 8'd1, 8'h33, 16'h0055, 1'b1);
    void'(tx_q.pop_back());
    while (tx_q.size() > 1) send_word(tx_q.pop_front(), 1'b0);
    send_word(tx_q.pop_front(), 1'b1);
    wait_idle(100);
    check_counts("fe_csum", 1, 0, 0);

    // Reset mid-data with a committed packet still unread
    ready_mode = 1;
    build_pkt(8'hAB, 8'd1, 8'h44, 16'h0100, 1'b1);
    send_tx();
    send_word(16'hAB00, 1'b0);
    send_word(16'h0455, 1'b0);
    send_word(16'h0001, 1'b0);
    send_word(16'h0002, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    #2;
    check("midrst_flags", {25'd0, bus.out_valid, bus.out_first, bus.out_last, bus.pkt_ok,
                           bus.err_csum, bus.err_ovf, bus.busy}, 32'd0);
    check("midrst_data", {16'd0, bus.out_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_mode = 0;
    repeat (10) begin @(posedge clk); #1; end
    check("postrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_counts("midrst", 1, 0, 0);

    // 20 size-2 packets wrap the pointers several times
    for (int p = 0; p < 20; p++) build_pkt(8'hAB, 8'd2, 8'(p), 16'(p * 16), 1'b1);
    send_tx();
    wait_idle(500);
    check_counts("wrap", 20, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
